// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer state encoding, default widths.
package alu_pkg;

    localparam int ALU_W  = 32;
    localparam int ALU_LW = 4;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu_word_sequencer.sv
// Feeds an external combinational ALU one operand pair per cycle, chaining carry for ADD.
// Result is registered 1 cycle after the input fire; input stalls while the output register is full and not draining.
module alu_word_sequencer
    import alu_pkg::*;
#(
    parameter int W  = ALU_W,
    parameter int LW = ALU_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_cin,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic          out_carry,
    output logic          out_last,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_op,
    output logic          alu_c_in,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_c_out,
    output logic          busy
);

    seq_state_t    state;
    logic [2:0]    op_reg;
    logic [LW-1:0] len_m1;
    logic [LW-1:0] count;
    logic          carry_reg;
    logic          in_fire;
    logic          is_last;

    // The ALU sits outside this block; operands go straight through so the
    // in_a -> ALU -> out_result path carries no extra logic.
    assign alu_a    = in_a;
    assign alu_b    = in_b;
    assign alu_op   = op_reg;
    assign alu_c_in = carry_reg;

    assign cmd_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign is_last   = (count == len_m1);
    assign busy      = (state == ST_RUN) || out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_reg     <= 3'd0;
            len_m1     <= '0;
            count      <= '0;
            carry_reg  <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= cmd_op;
                        len_m1    <= cmd_len;
                        carry_reg <= cmd_cin;
                        count     <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        out_result <= alu_result;
                        out_carry  <= alu_c_out;
                        out_last   <= is_last;
                        out_valid  <= 1'b1;
                        if (op_reg == OP_ADD) begin
                            carry_reg <= alu_c_out;
                        end
                        // Clearing on the last word keeps count within len_m1 even for 2^LW words.
                        if (is_last) begin
                            count <= '0;
                            state <= ST_IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
module tb_alu_word_sequencer;

    localparam int W      = 32;
    localparam int LW     = 4;
    localparam int NCMD   = 40;
    localparam int MAXW   = 16;
    localparam int NWMAX  = NCMD * MAXW;
    localparam int BW     = MAXW * W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic          cmd_cin;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry;
    logic          out_last;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic          alu_c_in;
    logic [W-1:0]  alu_result;
    logic          alu_c_out;
    logic          busy;

    alu_word_sequencer #(.W(W), .LW(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_cin(cmd_cin),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
        .out_last(out_last),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
        .alu_result(alu_result), .alu_c_out(alu_c_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the parent's combinational ALU.
    function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
        case (op)
            3'd0:    alu_fn = {1'b0, a};
            3'd1:    alu_fn = {1'b0, ~a};
            3'd2:    alu_fn = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            3'd3:    alu_fn = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            3'd4:    alu_fn = {1'b0, a | b};
            3'd5:    alu_fn = {1'b0, a & b};
            default: alu_fn = '0;
        endcase
    endfunction

    always_comb {alu_c_out, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_c_in);

    typedef struct packed {
        logic [W-1:0] res;
        logic         car;
        logic         last;
    } out_exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic       cin;
    } drv_exp_t;

    out_exp_t exp_q[$];
    drv_exp_t drv_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [2:0]    c_op   [NCMD];
    logic [LW-1:0] c_len  [NCMD];
    logic          c_cin  [NCMD];
    int            c_base [NCMD];
    logic [W-1:0]  wa [NWMAX];
    logic [W-1:0]  wb [NWMAX];
    int            total_words;
    bit            done;
    int            words_left;

    function automatic logic [W-1:0] rnd_word();
        return ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
    endfunction

    // Multi-word ADD is modelled as one wide addition; other ops are word-independent.
    task automatic push_expect(input int k);
        logic [BW-1:0] big_a, big_b, sum, part, mask, one;
        logic          prev_c, c_i;
        int            n;
        n      = int'(c_len[k]) + 1;
        big_a  = '0;
        big_b  = '0;
        one    = '0;
        one[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            big_a[i*W +: W] = wa[c_base[k] + i];
            big_b[i*W +: W] = wb[c_base[k] + i];
        end
        sum    = big_a + big_b + BW'(c_cin[k]);
        prev_c = c_cin[k];
        for (int i = 0; i < n; i++) begin
            if (c_op[k] == 3'd2) begin
                mask = (one << (W * (i + 1))) - one;
                part = (big_a & mask) + (big_b & mask) + BW'(c_cin[k]);
                c_i  = part[W * (i + 1)];
                exp_q.push_back('{res: sum[i*W +: W], car: c_i, last: (i == n - 1)});
                drv_q.push_back('{op: c_op[k], cin: prev_c});
                prev_c = c_i;
            end else begin
                logic [W:0] r;
                r = alu_fn(c_op[k], wa[c_base[k] + i], wb[c_base[k] + i], c_cin[k]);
                exp_q.push_back('{res: r[W-1:0], car: r[W], last: (i == n - 1)});
                drv_q.push_back('{op: c_op[k], cin: c_cin[k]});
            end
        end
    endtask

    task automatic gen_stimulus();
        int idx = 0;
        for (int k = 0; k < NCMD; k++) begin
            case (k)
                0:       begin c_op[k] = 3'd2; c_len[k] = 4'd0;  c_cin[k] = 1'b1; end
                1:       begin c_op[k] = 3'd2; c_len[k] = 4'd1;  c_cin[k] = 1'b0; end
                2:       begin c_op[k] = 3'd4; c_len[k] = 4'd2;  c_cin[k] = 1'b1; end
                3:       begin c_op[k] = 3'd2; c_len[k] = 4'd15; c_cin[k] = 1'($urandom); end
                default: begin
                    c_op[k]  = 3'($urandom_range(0, 7));
                    c_len[k] = ($urandom_range(0, 9) == 0) ? 4'd15 : LW'($urandom_range(0, 5));
                    c_cin[k] = 1'($urandom);
                end
            endcase
            c_base[k] = idx;
            for (int i = 0; i <= int'(c_len[k]); i++) begin
                wa[idx] = rnd_word();
                wb[idx] = rnd_word();
                idx++;
            end
        end
        wa[0] = 32'd5;          wb[0] = 32'd7;
        wa[1] = 32'hFFFF_FFFF;  wb[1] = 32'd1;
        wa[2] = 32'd0;          wb[2] = 32'd0;
        total_words = idx;
    endtask

    task automatic cmd_driver();
        bit f;
        int n;
        for (int k = 0; k < NCMD; k++) begin
            cmd_op    = c_op[k];
            cmd_len   = c_len[k];
            cmd_cin   = c_cin[k];
            cmd_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                f = cmd_valid && cmd_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!f && n < 3000 && !done);
            if (!f) begin
                check("cmd_accept_timeout", 64'(n), 64'(0));
                break;
            end
            push_expect(k);
            // Mostly keep cmd_valid high so it is also presented during RUN.
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic data_driver();
        int  idx = 0;
        bit  f;
        int  n = 0;
        while (idx < total_words && !done && n < 40000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = in_valid ? wa[idx] : W'($urandom);
            in_b     = in_valid ? wb[idx] : W'($urandom);
            @(negedge clk);
            f = in_valid && in_ready;
            @(posedge clk);
            #1;
            n++;
            if (f) idx++;
        end
        in_valid = 1'b0;
    endtask

    task automatic ready_driver();
        while (!done) begin
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic monitor();
        int       seen = 0;
        int       cyc  = 0;
        bit       hold = 1'b0;
        out_exp_t held;
        out_exp_t e;
        drv_exp_t d;
        words_left = 0;
        while (seen < total_words && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                check("stall_stable", {out_valid, out_result, out_carry, out_last},
                      {1'b1, held.res, held.car, held.last});
            end
            hold = out_valid && !out_ready;
            held = '{res: out_result, car: out_carry, last: out_last};
            if (cmd_valid && cmd_ready) begin
                check("cmd_accepted_in_run", 64'(words_left), 64'(0));
                words_left += int'(cmd_len) + 1;
            end
            if (in_valid && in_ready) begin
                if (words_left == 0) begin
                    check("in_accepted_in_idle", 64'(1), 64'(0));
                end else begin
                    words_left--;
                end
                if (drv_q.size() == 0) begin
                    check("alu_drive_unexpected", 64'(1), 64'(0));
                end else begin
                    d = drv_q.pop_front();
                    check("alu_op_cin", {alu_op, alu_c_in}, {d.op, d.cin});
                end
            end
            if (out_valid && out_ready) begin
                seen++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_result, out_carry, out_last}, {e.res, e.car, e.last});
                end
            end
        end
        check("out_count", 64'(seen), 64'(total_words));
        done = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_cin   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        done      = 1'b0;
        gen_stimulus();
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", {cmd_ready, in_ready, out_valid, out_result, out_carry, out_last, busy},
              {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        step();

        fork
            cmd_driver();
            data_driver();
            ready_driver();
            monitor();
        join
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of a 4-word ADD.
        out_ready = 1'b1;
        cmd_op = 3'd2; cmd_len = 4'd3; cmd_cin = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        check("idle_before_cmd", {cmd_ready, in_ready}, {1'b1, 1'b0});
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
        @(negedge clk);
        check("run_in_ready", {cmd_ready, in_ready}, {1'b0, 1'b1});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_word0", {out_valid, out_result, out_carry, out_last, busy},
              {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1});
        reset = 1'b1;
        #1;
        check("async_reset", {out_valid, out_result, out_carry, out_last, busy, cmd_ready},
              {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        step();
        reset = 1'b0;
        @(negedge clk);
        check("after_reset", {cmd_ready, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
        step();

        cmd_op = 3'd2; cmd_len = 4'd0; cmd_cin = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7;
        @(negedge clk);
        check("fresh_cmd_drive", {in_ready, alu_op, alu_c_in}, {1'b1, 3'd2, 1'b1});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("fresh_cmd_result", {out_valid, out_result, out_carry, out_last, cmd_ready},
              {1'b1, 32'd13, 1'b0, 1'b1, 1'b1});
        step();
        @(negedge clk);
        check("drained_idle", {out_valid, busy, cmd_ready}, {1'b0, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
